// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg -- shared definitions for the fetch sequencer.
//   fetch_state_e : sequencer FSM states
//   PC_INC        : sequential fetch stride in bytes
//   ALIGN_MASK    : clears pc[1:0]; slice/cast to XLEN at the point of use
//   CNT_W         : width of the performance counters
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INC     = 4;
    localparam logic [63:0] ALIGN_MASK = ~64'h3;
    localparam int unsigned CNT_W      = 32;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if -- control, memory and decoder-side signals of the
// fetch sequencer.
//   master : the sequencer (drives mem_addr, out_*, halted, counters)
//   slave  : the environment (drives run/halt/redirect, mem_rdata, out_ready)
interface fetch_sequencer_if
    import fetch_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic             run;
    logic             halt_req;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_instr;
    logic [XLEN-1:0]  out_pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] stall_count;

    modport master (
        input  run, halt_req, redirect_valid, redirect_pc, mem_rdata, out_ready,
        output mem_addr, out_valid, out_instr, out_pc, halted, fetch_count, stall_count
    );

    modport slave (
        output run, halt_req, redirect_valid, redirect_pc, mem_rdata, out_ready,
        input  mem_addr, out_valid, out_instr, out_pc, halted, fetch_count, stall_count
    );
endinterface

// File: rtl/fetch_seq_perf.sv
// fetch_seq_perf -- wrapping performance counters for the fetch sequencer.
//   clk, rst_n  : clock, async active-low reset
//   fire        : instruction handed to the decoder this cycle
//   stall       : valid instruction held by the decoder this cycle
//   fetch_count : number of fire cycles (wraps)
//   stall_count : number of stall cycles (wraps)
// The module body is only elaborated when FETCH_SEQ_PERF_EN is defined, so
// the default build carries no dangling counter module.
`ifdef FETCH_SEQ_PERF_EN
module fetch_seq_perf
    import fetch_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fire,
    input  logic             stall,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, fire};
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, stall};
        end
    end
endmodule
`endif

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- instruction fetch sequencer in front of a synchronous
// instruction memory (read data arrives the cycle after mem_addr).
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_sequencer_if.master
//     run / halt_req         start-resume / stop-and-drain requests
//     redirect_valid/_pc     branch redirect, wins over stall and halt
//     mem_addr / mem_rdata   memory address out, instruction word in
//     out_valid/ready/instr/pc  decoder handshake (out_instr = mem_rdata)
//     halted                 high in IDLE and HALTED
//     fetch_count/stall_count  performance counters
// Optional: define FETCH_SEQ_PERF_EN to build the counters; otherwise both
// counter outputs are tied to zero.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    localparam logic [XLEN-1:0] PC_MASK = XLEN'(ALIGN_MASK);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
    logic            inflight_v, inflight_v_nxt;
    logic            stall;
    logic            issue;

    assign stall = inflight_v & ~bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC & PC_MASK;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight_v  <= inflight_v_nxt;
            inflight_pc <= inflight_pc_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inflight_v_nxt  = inflight_v;
        inflight_pc_nxt = inflight_pc;
        issue           = 1'b0;
        unique case (state)
            S_RUN: begin
                if (bus.redirect_valid) begin
                    pc_nxt         = bus.redirect_pc & PC_MASK;
                    inflight_v_nxt = 1'b0;
                end else if (stall) begin
                    if (bus.halt_req) state_nxt = S_DRAIN;
                end else begin
                    // A halt without stall still lets this cycle's fetch land,
                    // so the decoder sees one last instruction in HALTED.
                    issue = 1'b1;
                    if (bus.halt_req) state_nxt = S_HALTED;
                end
            end
            S_DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_nxt         = bus.redirect_pc & PC_MASK;
                    inflight_v_nxt = 1'b0;
                    state_nxt      = S_RUN;
                end else if (!stall) begin
                    inflight_v_nxt = 1'b0;
                    state_nxt      = S_HALTED;
                end
            end
            S_IDLE, S_HALTED: begin
                if (!stall) inflight_v_nxt = 1'b0;
                if (!bus.halt_req && bus.run) state_nxt = S_RUN;
            end
        endcase
        if (issue) begin
            inflight_v_nxt  = 1'b1;
            inflight_pc_nxt = pc;
            pc_nxt          = pc + PC_STEP;
        end
    end

    // While a word is held (stall, or draining) the memory re-reads its
    // address so out_instr stays stable on the following cycle.
    assign bus.mem_addr  = (state == S_DRAIN || stall) ? inflight_pc : pc;
    assign bus.out_valid = inflight_v;
    assign bus.out_pc    = inflight_pc;
    assign bus.out_instr = bus.mem_rdata;
    assign bus.halted    = (state == S_IDLE) || (state == S_HALTED);

`ifdef FETCH_SEQ_PERF_EN
    fetch_seq_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fire        (inflight_v & bus.out_ready),
        .stall       (stall),
        .fetch_count (bus.fetch_count),
        .stall_count (bus.stall_count)
    );
`else
    assign bus.fetch_count = '0;
    assign bus.stall_count = '0;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset (bits [1:0] forced 0).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port run  input  1  start/resume fetching from IDLE or HALTED.
REQ-006 SHALL have port halt_req  input  1  stop issuing, drain, enter HALTED.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-009 SHALL have port mem_addr  output  XLEN  address to synchronous instruction memory (data returned next cycle).
REQ-010 SHALL have port mem_rdata  input  XLEN  instruction word from memory.
REQ-011 SHALL have port out_valid  output  1  instruction presented to decoder.
REQ-012 SHALL have port out_ready  input  1  decoder accepts instruction.
REQ-013 SHALL have port out_instr  output  XLEN  instruction (equals mem_rdata).
REQ-014 SHALL have port out_pc  output  XLEN  address of out_instr.
REQ-015 SHALL have port halted  output  1  high in IDLE and HALTED.
REQ-016 SHALL have ports fetch_count and stall_count  output  32  performance counters.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, HALTED.
REQ-018 Registers: pc (next fetch address), inflight_v, inflight_pc; out_valid = inflight_v, out_pc = inflight_pc; stall = out_valid & ~out_ready.
REQ-019 IDLE/HALTED -> RUN when run=1; no issue in the transition cycle; mem_addr = pc.
REQ-020 RUN, no redirect, no stall: mem_addr = pc; next edge inflight_v=1, inflight_pc=pc, pc=pc+4 (mod 2^XLEN, wraps to 0).
REQ-021 RUN with stall: mem_addr = inflight_pc (memory re-reads, out_instr stays stable); pc and inflight unchanged.
REQ-022 redirect_valid in RUN or DRAIN has priority over stall and halt_req: next edge pc = redirect_pc & ~3, inflight_v=0, state RUN; first valid target instruction appears 2 cycles after the redirect cycle.
REQ-023 halt_req in RUN (no redirect): if no stall, RUN -> HALTED with inflight_v kept for one final presentation; else RUN -> DRAIN.
REQ-024 DRAIN: mem_addr = inflight_pc; no new issue; on ~stall -> HALTED.
REQ-025 HALTED/IDLE: no issue; inflight_v cleared once accepted or if ~out_valid; pc preserved for resume.
REQ-026 Simultaneous run and halt_req in IDLE/HALTED: halt_req wins, remain in place.
REQ-027 Fetch-to-valid latency 1 cycle; sustained throughput 1 instruction/cycle with out_ready=1.

Reset
REQ-028 rst_n low SHALL immediately clear: state=IDLE, pc=RESET_PC, inflight_v=0, out_valid=0, counters=0, halted=1, mem_addr=RESET_PC.
REQ-029 Reset mid-fetch SHALL discard the in-flight instruction; no handshake completes in the reset cycle.

Configuration
REQ-030 Macro FETCH_SEQ_PERF_EN defined: fetch_count increments on each out_valid&out_ready, stall_count increments each stall cycle, both wrap at 2^32.
REQ-031 FETCH_SEQ_PERF_EN undefined: counters absent, fetch_count and stall_count tied to 0; all other behaviour identical.

Structure
REQ-032 Shared package fetch_seq_pkg SHALL hold the state enum, the PC increment constant 4 and the alignment mask.
REQ-033 Counters SHALL be in one sub-module fetch_seq_perf, instantiated only under FETCH_SEQ_PERF_EN.

Verification
REQ-034 Reset release, run=1 pulse, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles from the 2nd cycle after run, mem_addr one step ahead.
REQ-035 out_ready=0 for 3 cycles at out_pc=8 -> out_pc/out_instr hold 8 and the same word, mem_addr=8, stall_count=3 (PERF_EN), then 12 follows.
REQ-036 redirect_valid with redirect_pc=0x43 while stalled -> out_valid 0 next cycle, then out_pc=0x40, stall ignored.
REQ-037 halt_req during stall -> DRAIN until out_ready, then HALTED, halted=1; run -> resumes at the next sequential pc with no duplicate or skip.
REQ-038 pc=0xFFFFFFFC running -> next out_pc 0x00000000; rst_n low mid-stream -> out_valid 0 asynchronously, pc=RESET_PC.
